// File: rtl/dec_str_parser_pkg.sv
// Shared constants and state encoding for the streaming decimal parser.
package dec_str_parser_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/dec_str_parser_digit_decode.sv
// Combinational ASCII digit classifier: '0'..'9' -> 0..9, everything else
// reports is_digit=0 with digit=0.
module ascii_digit_decode
  import dec_str_parser_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] digit,
  output logic       is_digit
);

  // Classify the character; the low nibble of '0'..'9' is the digit value.
  always_comb begin
    digit    = 4'd0;
    is_digit = 1'b0;
    if ((ch >= ASCII_0) && (ch <= ASCII_9)) begin
      digit    = ch[3:0];
      is_digit = 1'b1;
    end else begin
      digit    = 4'd0;
      is_digit = 1'b0;
    end
  end

endmodule

// File: rtl/dec_str_parser.sv
// Streaming ASCII-decimal to binary converter with valid/ready on both sides.
// Optional build macro DEC_STR_PARSER_SIGNED_EN enables a leading '-' and
// two's-complement, saturating signed output.
module dec_str_parser
  import dec_str_parser_pkg::*;
#(
  parameter int         MAX_DIGITS = 12,
  parameter int         VAL_W      = 64,
  parameter logic [7:0] DELIM      = ASCII_CR,
  parameter int         CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VAL_W-1:0] out_value,
  output logic [CNT_W-1:0] out_ndigits,
  output logic             out_err_fmt,
  output logic             out_err_ovf
);

  state_t             state;
  state_t             next_state;
  logic [VAL_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               fmt;
  logic               ovf;
  logic [3:0]         digit;
  logic               is_digit;
  logic               consume;
  logic               out_fire;
  logic               is_delim;
  logic               cnt_full;
  logic [VAL_W+3:0]   prod;
  logic               dig_ovf;
  logic [VAL_W-1:0]   result;

`ifdef DEC_STR_PARSER_SIGNED_EN
  localparam logic [VAL_W+3:0] POS_LIM = {5'b00000, {(VAL_W-1){1'b1}}};
  localparam logic [VAL_W+3:0] NEG_LIM = {4'b0000, 1'b1, {(VAL_W-1){1'b0}}};
  logic neg;
`endif

  ascii_digit_decode u_digit_decode (
    .ch       (in_data),
    .digit    (digit),
    .is_digit (is_digit)
  );

  assign consume  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign is_delim = (in_data == DELIM);
  assign cnt_full = (cnt == CNT_W'(MAX_DIGITS));

  // acc*10 + digit in a widened accumulator so carries past VAL_W are visible.
  always_comb begin
    prod = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{VAL_W{1'b0}}, digit};
  end

  // A digit overflows when the count is already full or the value leaves range.
  always_comb begin
    dig_ovf = cnt_full || (prod[VAL_W+3:VAL_W] != 4'd0);
`ifdef DEC_STR_PARSER_SIGNED_EN
    if (neg) begin
      dig_ovf = dig_ovf || (prod > NEG_LIM);
    end else begin
      dig_ovf = dig_ovf || (prod > POS_LIM);
    end
`endif
  end

  // Final value presented at the delimiter, saturated on overflow.
  always_comb begin
    result = acc;
`ifdef DEC_STR_PARSER_SIGNED_EN
    if (ovf) begin
      result = neg ? {1'b1, {(VAL_W-1){1'b0}}} : {1'b0, {(VAL_W-1){1'b1}}};
    end else if (neg) begin
      result = ~acc + {{(VAL_W-1){1'b0}}, 1'b1};
    end else begin
      result = acc;
    end
`else
    if (ovf) begin
      result = {VAL_W{1'b1}};
    end else begin
      result = acc;
    end
`endif
  end

  // Next-state logic: characters move IDLE/ACCUM forward, result handshake returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, ACCUM: begin
        if (consume) begin
          next_state = is_delim ? OUT : ACCUM;
        end else begin
          next_state = state;
        end
      end
      OUT: begin
        if (out_fire) begin
          next_state = IDLE;
        end else begin
          next_state = OUT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; in_ready is registered so it stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != OUT);
    end
  end

  // Accumulator, sticky flags and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= {VAL_W{1'b0}};
      cnt         <= {CNT_W{1'b0}};
      fmt         <= 1'b0;
      ovf         <= 1'b0;
      out_valid   <= 1'b0;
      out_value   <= {VAL_W{1'b0}};
      out_ndigits <= {CNT_W{1'b0}};
      out_err_fmt <= 1'b0;
      out_err_ovf <= 1'b0;
`ifdef DEC_STR_PARSER_SIGNED_EN
      neg         <= 1'b0;
`endif
    end else if (state == OUT) begin
      if (out_fire) begin
        out_valid <= 1'b0;
        acc       <= {VAL_W{1'b0}};
        cnt       <= {CNT_W{1'b0}};
        fmt       <= 1'b0;
        ovf       <= 1'b0;
`ifdef DEC_STR_PARSER_SIGNED_EN
        neg       <= 1'b0;
`endif
      end
    end else if (consume) begin
      if (is_delim) begin
        out_valid   <= 1'b1;
        out_value   <= result;
        out_ndigits <= cnt;
        out_err_fmt <= fmt || (cnt == {CNT_W{1'b0}});
        out_err_ovf <= ovf;
      end else if (is_digit) begin
        if (ovf || dig_ovf) begin
          ovf <= 1'b1;
        end else begin
          acc <= prod[VAL_W-1:0];
        end
        if (!cnt_full) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
`ifdef DEC_STR_PARSER_SIGNED_EN
      else if ((in_data == ASCII_MINUS) && (state == IDLE)) begin
        neg <= 1'b1;
      end
`endif
      else begin
        fmt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dec_str_parser.sv
// Randomized + directed bench for dec_str_parser. Two instances (VAL_W=64 and
// VAL_W=8) share one input stream and are checked every cycle against a
// string-level reference model.
module tb_dec_str_parser;

  localparam int         MAXD = 12;
  localparam int         CW   = 4;
  localparam logic [7:0] CR   = 8'h0D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        in_ready_a, out_valid_a, err_fmt_a, err_ovf_a;
  logic [63:0] out_value_a;
  logic [CW-1:0] out_nd_a;
  logic        in_ready_b, out_valid_b, err_fmt_b, err_ovf_b;
  logic [7:0]  out_value_b;
  logic [CW-1:0] out_nd_b;

  dec_str_parser #(.MAX_DIGITS(MAXD), .VAL_W(64), .DELIM(8'h0D)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_value(out_value_a), .out_ndigits(out_nd_a),
    .out_err_fmt(err_fmt_a), .out_err_ovf(err_ovf_a));

  dec_str_parser #(.MAX_DIGITS(MAXD), .VAL_W(8), .DELIM(8'h0D)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_value(out_value_b), .out_ndigits(out_nd_b),
    .out_err_fmt(err_fmt_b), .out_err_ovf(err_ovf_b));

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned acc;
    int              cnt;
    bit              fmt;
    bit              ovf;
    bit              neg;
    bit              started;
  } mst_t;

  typedef struct {
    longint unsigned value;
    int              nd;
    bit              fmt;
    bit              ovf;
  } res_t;

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned txq[$];
  int   ordy_mode = 0;   // 0: always ready, 1: random, 2: never
  bit   gap_en = 1'b0;
  res_t got_a[$];
  res_t got_b[$];

  mst_t ma, mb;
  res_t ea, eb;
  bit   m_pend, m_rdy;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned wmask(int w);
    if (w >= 64) return 64'hFFFF_FFFF_FFFF_FFFF;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic mst_t m_init();
    mst_t s;
    s.acc = 0; s.cnt = 0; s.fmt = 0; s.ovf = 0; s.neg = 0; s.started = 0;
    return s;
  endfunction

  // One consumed non-delimiter character, in terms of decimal arithmetic.
  function automatic mst_t m_step(mst_t s, byte unsigned c, int w);
    longint unsigned lim, d;
    if (c >= 8'h30 && c <= 8'h39) begin
      d   = longint'(c) - 48;
      lim = wmask(w);
`ifdef DEC_STR_PARSER_SIGNED_EN
      lim = s.neg ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
`endif
      if (s.ovf || s.cnt == MAXD || s.acc > (lim - d) / 10) s.ovf = 1'b1;
      else s.acc = s.acc * 10 + d;
      if (s.cnt < MAXD) s.cnt++;
    end
`ifdef DEC_STR_PARSER_SIGNED_EN
    else if (c == 8'h2D && !s.started) s.neg = 1'b1;
`endif
    else s.fmt = 1'b1;
    s.started = 1'b1;
    return s;
  endfunction

  function automatic res_t m_finish(mst_t s, int w);
    res_t r;
    longint unsigned m = wmask(w);
    r.nd  = s.cnt;
    r.fmt = s.fmt || (s.cnt == 0);
    r.ovf = s.ovf;
`ifdef DEC_STR_PARSER_SIGNED_EN
    if (s.ovf) r.value = s.neg ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
    else if (s.neg) r.value = (64'd0 - s.acc) & m;
    else r.value = s.acc;
`else
    r.value = s.ovf ? m : s.acc;
`endif
    return r;
  endfunction

  function automatic res_t parse_str(string str, int w);
    mst_t s = m_init();
    for (int i = 0; i < str.len(); i++) s = m_step(s, byte'(str[i]), w);
    return m_finish(s, w);
  endfunction

  // Reference model: advances on each clock edge from the observed inputs.
  initial begin : model
    ma = m_init(); mb = m_init(); m_pend = 1'b0; m_rdy = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ma = m_init(); mb = m_init(); m_pend = 1'b0; m_rdy = 1'b0;
      end else begin
        if (m_pend && out_ready) begin
          m_pend = 1'b0;
        end else if (m_rdy && in_valid) begin
          if (in_data == CR) begin
            ea = m_finish(ma, 64); eb = m_finish(mb, 8);
            m_pend = 1'b1; ma = m_init(); mb = m_init();
          end else begin
            ma = m_step(ma, in_data, 64); mb = m_step(mb, in_data, 8);
          end
        end
        m_rdy = !m_pend;
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  initial begin : compare
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready_a", 64'(in_ready_a), 64'd0);
        chk("rst_out_valid_a", 64'(out_valid_a), 64'd0);
        chk("rst_out_valid_b", 64'(out_valid_b), 64'd0);
        chk("rst_value_a", out_value_a, 64'd0);
      end else begin
        chk("in_ready_a", 64'(in_ready_a), 64'(m_rdy));
        chk("in_ready_b", 64'(in_ready_b), 64'(m_rdy));
        chk("out_valid_a", 64'(out_valid_a), 64'(m_pend));
        chk("out_valid_b", 64'(out_valid_b), 64'(m_pend));
        if (m_pend) begin
          chk("value_a", out_value_a, ea.value);
          chk("nd_a", 64'(out_nd_a), 64'(ea.nd));
          chk("fmt_a", 64'(err_fmt_a), 64'(ea.fmt));
          chk("ovf_a", 64'(err_ovf_a), 64'(ea.ovf));
          chk("value_b", 64'(out_value_b), eb.value);
          chk("nd_b", 64'(out_nd_b), 64'(eb.nd));
          chk("fmt_b", 64'(err_fmt_b), 64'(eb.fmt));
          chk("ovf_b", 64'(err_ovf_b), 64'(eb.ovf));
        end
        if (out_valid_a && out_ready) begin
          r.value = out_value_a; r.nd = int'(out_nd_a); r.fmt = err_fmt_a; r.ovf = err_ovf_a;
          got_a.push_back(r);
        end
        if (out_valid_b && out_ready) begin
          r.value = 64'(out_value_b); r.nd = int'(out_nd_b); r.fmt = err_fmt_b; r.ovf = err_ovf_b;
          got_b.push_back(r);
        end
      end
    end
  end

  // Input driver: holds each character until it is accepted.
  initial begin : driver
    bit hs;
    forever begin
      @(negedge clk);
      hs = in_valid && in_ready_a;
      @(posedge clk);
      #1;
      if (hs && txq.size() > 0) void'(txq.pop_front());
      if (txq.size() == 0) in_valid = 1'b0;
      else if (!in_valid || hs) in_valid = !gap_en || ($urandom_range(0, 3) != 0);
      in_data = (txq.size() > 0) ? txq[0] : 8'h00;
      case (ordy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(string str, bit with_cr);
    for (int i = 0; i < str.len(); i++) txq.push_back(byte'(str[i]));
    if (with_cr) txq.push_back(CR);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((txq.size() != 0 || in_valid || m_pend) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 64'(k >= 5000), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_res(string name, bit use_b, int idx, longint unsigned v, int nd, bit fmt, bit ovf);
    res_t r;
    int   sz = use_b ? got_b.size() : got_a.size();
    chk({name, "_present"}, 64'(idx < sz), 64'd1);
    if (idx < sz) begin
      r = use_b ? got_b[idx] : got_a[idx];
      chk({name, "_value"}, r.value, v);
      chk({name, "_nd"}, 64'(r.nd), 64'(nd));
      chk({name, "_fmt"}, 64'(r.fmt), 64'(fmt));
      chk({name, "_ovf"}, 64'(r.ovf), 64'(ovf));
    end
  endtask

  task automatic clear_got();
    got_a.delete();
    got_b.delete();
  endtask

  initial begin : main
    res_t p;
    // Hand-computed pins on the reference model itself.
    p = parse_str("123456789012", 64);
    chk("pin_12dig", p.value, 64'd123456789012);
    p = parse_str("12a3", 64);
    chk("pin_fmt_val", p.value, 64'd123);
    chk("pin_fmt_flag", 64'(p.fmt), 64'd1);
    p = parse_str("256", 8);
    chk("pin_w8_ovf", 64'(p.ovf), 64'd1);
`ifdef DEC_STR_PARSER_SIGNED_EN
    p = parse_str("-128", 8);
    chk("pin_neg128", p.value, 64'h80);
`else
    p = parse_str("255", 8);
    chk("pin_w8_255", p.value, 64'hFF);
`endif

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 12 digits, always ready.
    ordy_mode = 0; gap_en = 1'b0; clear_got();
    send("123456789012", 1'b1);
    wait_idle();
    chk_res("twelve", 1'b0, 0, 64'd123456789012, 12, 1'b0, 1'b0);

    // 13 digits: digit-count overflow.
    clear_got();
    send("1234567890123", 1'b1);
    wait_idle();
`ifdef DEC_STR_PARSER_SIGNED_EN
    chk_res("thirteen", 1'b0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 12, 1'b0, 1'b1);
`else
    chk_res("thirteen", 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 12, 1'b0, 1'b1);
`endif

    // 8-bit value overflow boundary.
    clear_got();
    send("256", 1'b1);
    send("255", 1'b1);
    wait_idle();
`ifdef DEC_STR_PARSER_SIGNED_EN
    chk_res("w8_256", 1'b1, 0, 64'h7F, 3, 1'b0, 1'b1);
    chk_res("w8_255", 1'b1, 1, 64'h7F, 3, 1'b0, 1'b1);
`else
    chk_res("w8_256", 1'b1, 0, 64'hFF, 3, 1'b0, 1'b1);
    chk_res("w8_255", 1'b1, 1, 64'hFF, 3, 1'b0, 1'b0);
`endif

    // Format error and empty number.
    clear_got();
    send("12a3", 1'b1);
    send("", 1'b1);
    send("000", 1'b1);
    wait_idle();
    chk_res("fmt", 1'b0, 0, 64'd123, 3, 1'b1, 1'b0);
    chk_res("empty", 1'b0, 1, 64'd0, 0, 1'b1, 1'b0);
    chk_res("zeros", 1'b0, 2, 64'd0, 3, 1'b0, 1'b0);

    // Back-pressure: result held, input stalled, nothing dropped.
    clear_got();
    ordy_mode = 2;
    send("7", 1'b1);
    send("8", 1'b1);
    repeat (10) @(negedge clk);
    chk("hold_in_ready", 64'(in_ready_a), 64'd0);
    chk("hold_out_valid", 64'(out_valid_a), 64'd1);
    chk("hold_value", out_value_a, 64'd7);
    chk("hold_queued", 64'(txq.size()), 64'd2);
    ordy_mode = 0;
    wait_idle();
    chk_res("hold_first", 1'b0, 0, 64'd7, 1, 1'b0, 1'b0);
    chk_res("hold_second", 1'b0, 1, 64'd8, 1, 1'b0, 1'b0);

    // Reset in the middle of a number.
    clear_got();
    send("45", 1'b0);
    begin
      int k = 0;
      while (txq.size() != 0 && k < 100) begin @(negedge clk); k++; end
      chk("mid_timeout", 64'(k >= 100), 64'd0);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    txq.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_got();
    send("6", 1'b1);
    wait_idle();
    chk_res("after_reset", 1'b0, 0, 64'd6, 1, 1'b0, 1'b0);

`ifdef DEC_STR_PARSER_SIGNED_EN
    clear_got();
    send("-128", 1'b1);
    send("-129", 1'b1);
    send("128", 1'b1);
    send("-", 1'b1);
    send("1-2", 1'b1);
    wait_idle();
    chk_res("s_m128", 1'b1, 0, 64'h80, 3, 1'b0, 1'b0);
    chk_res("s_m129", 1'b1, 1, 64'h80, 3, 1'b0, 1'b1);
    chk_res("s_128", 1'b1, 2, 64'h7F, 3, 1'b0, 1'b1);
    chk_res("s_minus", 1'b1, 3, 64'd0, 0, 1'b1, 1'b0);
    chk_res("s_inner", 1'b1, 4, 64'd12, 2, 1'b1, 1'b0);
`endif

    // Randomized traffic with random gaps and random back-pressure.
    ordy_mode = 1; gap_en = 1'b1;
    for (int n = 0; n < 250; n++) begin
      int len = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 14);
      if ($urandom_range(0, 7) == 0) txq.push_back(8'h2D);
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 99);
        if (r < 3) txq.push_back(8'h61);
        else if (r < 5) txq.push_back(8'h2D);
        else txq.push_back(8'(8'h30 + $urandom_range(0, 9)));
      end
      txq.push_back(CR);
      if (txq.size() > 64) wait_idle();
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_str_parser.md
Name: dec_str_parser

Overview:
- Streaming ASCII-decimal to unsigned binary converter. It replaces fixed-width combinational string-to-integer decode.
- Accepts one character per cycle over a valid/ready handshake. Accumulates acc = acc*10 + digit.
- On the delimiter, emits a VAL_W-bit result with format and overflow flags over a second valid/ready handshake.
- Sits between the UART RX byte stream and the calculator/display datapath.

Parameters:
- MAX_DIGITS, 12: maximum accepted digit count per number.
- VAL_W, 64: result width in bits.
- DELIM, 8'h0D: terminator character (CR).
- CNT_W, $clog2(MAX_DIGITS+1): digit-counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  character present on in_data.
- in_data  in  8  ASCII character.
- in_ready  out  1  parser can accept a character.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_value  out  VAL_W  converted value.
- out_ndigits  out  CNT_W  number of digits accepted, saturating at MAX_DIGITS.
- out_err_fmt  out  1  non-digit, non-delimiter seen, or empty number.
- out_err_ovf  out  1  digit-count or value overflow.

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=0, cnt=0, all error flags 0, out_valid=0, out_value=0, out_ndigits=0, both out_err flags=0, in_ready=0 during reset then 1.
- States:
  - IDLE: no digits yet.
  - ACCUM: at least one character consumed.
  - OUT: result held.
- in_ready = 1 in IDLE/ACCUM, 0 in OUT. A character is consumed only when in_valid && in_ready.
- Consumed digit '0'..'9':
  - acc <= acc*10 + d. Implement *10 as (acc<<3)+(acc<<1), computed in VAL_W+4 bits.
  - If any bit above VAL_W-1 is set, or cnt==MAX_DIGITS, set sticky ovf. When ovf is set, acc holds its previous value.
  - cnt increments, saturating at MAX_DIGITS. IDLE->ACCUM.
- Consumed DELIM:
  - Go to OUT. out_valid=1 next cycle (1-cycle latency from delimiter acceptance).
  - out_value = acc, or all-ones if ovf. out_ndigits = cnt.
  - out_err_fmt = fmt | (cnt==0).
- Consumed any other character: set sticky fmt, discard the character, stay or go to ACCUM. The parse continues until DELIM.
- OUT: outputs stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid<=0, acc/cnt/flags cleared, state->IDLE, in_ready=1 the following cycle.
  - Characters presented during OUT are stalled, not dropped.
- Leading zeros count as digits: "000" = 3 digits, value 0.
- Delimiter immediately after a previous result gives out_value=0, out_ndigits=0, out_err_fmt=1.
- rst_n low mid-parse or mid-OUT aborts immediately to reset values. A pending result is lost.

Optional Feature:
- Macro: DEC_STR_PARSER_SIGNED_EN.
- Defined:
  - A '-' as the first consumed character (IDLE) sets neg. A '-' anywhere else is a format error.
  - At DELIM, out_value = neg ? -acc : acc (two's complement).
  - ovf also set if acc > 2^(VAL_W-1)-1 (positive) or acc > 2^(VAL_W-1) (negative).
  - Overflowed output saturates to the max positive or min negative value.
  - "-" alone gives out_err_fmt=1.
- Undefined: '-' is a plain format error; output is unsigned. No neg register is synthesised.

Decomposition:
- Shared package/header holds:
  - constants ASCII_0=8'h30, ASCII_9=8'h39, ASCII_CR=8'h0D, ASCII_MINUS=8'h2D;
  - state encoding (IDLE=2'd0, ACCUM=2'd1, OUT=2'd2).
- One combinational sub-module, ascii_digit_decode: 8-bit char in, 4-bit digit out, is_digit out. It has a defined default (digit=0, is_digit=0) for all non-digit codes: no latch.

Test Plan:
- "123456789012"+CR, out_ready=1: out_value=64'd123456789012, out_ndigits=12, both errors 0, out_valid exactly 1 cycle after CR.
- "1234567890123"+CR (13 digits): out_err_ovf=1, out_value=all-ones, out_ndigits=12, out_err_fmt=0.
- VAL_W=8, "256"+CR: out_err_ovf=1, out_value=8'hFF. Then "255"+CR: out_value=8'hFF, no error.
- "12a3"+CR: out_err_fmt=1, out_value=123, out_ndigits=3. CR alone: out_value=0, out_ndigits=0, out_err_fmt=1.
- Hold out_ready=0 for 5 cycles with "7"+CR then "8"+CR queued:
  - in_ready=0 and outputs stable throughout;
  - after handshake, the second result is 8;
  - no characters are lost.
- Assert rst_n low after "45" mid-parse, then send "6"+CR: out_value=6.
- SIGNED_EN, VAL_W=8:
  - "-128"+CR gives 8'h80, no error;
  - "-129"+CR gives ovf=1, 8'h80;
  - "128"+CR gives ovf=1, 8'h7F.
